// File: rtl/multdiv_controller_pkg.sv
// Shared constants, state encoding and retire payload for the execute-stage mult/div sequencer.
package multdiv_controller_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned REG_W  = 5;

  localparam logic [ALUOP_W-1:0] RTYPE_OPCODE = 5'b00000;
  localparam logic [ALUOP_W-1:0] MULT_ALUOP   = 5'b00110;
  localparam logic [ALUOP_W-1:0] DIV_ALUOP    = 5'b00111;

  localparam logic [XLEN-1:0] RSTATUS_MULT = 32'd4;
  localparam logic [XLEN-1:0] RSTATUS_DIV  = 32'd5;
  localparam logic [XLEN-1:0] RSTATUS_INSN = 32'h2F80_0000;
  localparam logic [XLEN-1:0] NOP_INSN     = 32'h0000_0000;

  localparam logic [CNT_W-1:0] TIMEOUT = 6'd40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] data;
  } md_retire_t;

  // R-type with a MUL or DIV ALUop field.
  function automatic logic is_muldiv(input logic [ALUOP_W-1:0] opcode,
                                     input logic [ALUOP_W-1:0] aluop);
    return (opcode == RTYPE_OPCODE) && ((aluop == MULT_ALUOP) || (aluop == DIV_ALUOP));
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Cycle counter bounding how long the sequencer waits for the mult/div unit.
module md_timeout_counter
  import multdiv_controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  logic [CNT_W-1:0] count_q;

  // Clear has priority so START always begins the wait from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    tc_c = (count_q == TIMEOUT);
  end

endmodule

// File: rtl/multdiv_controller.sv
// Execute-stage sequencer for the shared iterative mult/div unit: start, wait, retire or drain.
module multdiv_controller
  import multdiv_controller_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] insnIn,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            flush,
  input  logic [XLEN-1:0] md_result,
  input  logic            md_exception,
  input  logic            md_ready,
  output logic            ctrl_MULT,
  output logic            ctrl_DIV,
  output logic [XLEN-1:0] md_opA,
  output logic [XLEN-1:0] md_opB,
  output logic            stall,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] insnOut,
  output logic [XLEN-1:0] dataOut
);

  md_state_e       state_q;
  md_state_e       state_d;
  logic [XLEN-1:0] insn_q;
  logic            detect_c;
  logic            accept_c;
  logic            cnt_clear_c;
  logic            cnt_en_c;
  logic            tc_c;
  logic            retire_c;
  logic            exc_c;
  md_retire_t      retire_d;

  md_timeout_counter u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear_c),
    .enable (cnt_en_c),
    .tc_c   (tc_c)
  );

  always_comb begin
    detect_c = is_muldiv(insnIn[31:27], insnIn[6:2]);
    accept_c = (state_q == ST_IDLE) && detect_c && !flush;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter control and the retire decision.
  always_comb begin
    state_d     = state_q;
    cnt_clear_c = 1'b0;
    cnt_en_c    = 1'b0;
    retire_c    = 1'b0;
    exc_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_clear_c = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en_c = 1'b1;
        if (flush) begin
          // A unit that finishes in the flush cycle has nothing left to drain.
          state_d = (md_ready || tc_c) ? ST_IDLE : ST_DRAIN;
        end else if (md_ready) begin
          state_d  = ST_DONE;
          retire_c = 1'b1;
          exc_c    = md_exception;
        end else if (tc_c) begin
          state_d  = ST_DONE;
          retire_c = 1'b1;
          exc_c    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        cnt_en_c = 1'b1;
        if (md_ready || tc_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Retiring instruction/data; exceptions become a write of the rstatus code to $r30.
  always_comb begin
    retire_d.insn = insn_q;
    retire_d.data = md_result;
    if (exc_c) begin
      retire_d.insn = RSTATUS_INSN;
      retire_d.data = (insn_q[6:2] == DIV_ALUOP) ? RSTATUS_DIV : RSTATUS_MULT;
    end else if (insn_q[26:22] == REG_W'(0)) begin
      retire_d.data = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      insnOut   <= NOP_INSN;
      dataOut   <= '0;
      insn_q    <= NOP_INSN;
      md_opA    <= '0;
      md_opB    <= '0;
    end else begin
      ctrl_MULT <= accept_c && (insnIn[6:2] == MULT_ALUOP);
      ctrl_DIV  <= accept_c && (insnIn[6:2] == DIV_ALUOP);
      busy      <= (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
      out_valid <= retire_c;
      insnOut   <= retire_c ? retire_d.insn : NOP_INSN;
      dataOut   <= retire_c ? retire_d.data : '0;
      if (accept_c) begin
        insn_q <= insnIn;
        md_opA <= rs;
        md_opB <= rt;
      end
    end
  end

  // Stall must respond in the same cycle a MUL/DIV reaches execute.
  always_comb begin
    stall = reset && (accept_c
                      || (state_q == ST_START)
                      || (state_q == ST_WAIT)
                      || ((state_q == ST_DRAIN) && detect_c));
  end

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller with a cycle-level mult/div unit model.
module tb_multdiv_controller;

  logic        clock;
  logic        reset;
  logic [31:0] insnIn;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic        stall;
  logic        busy;
  logic        out_valid;
  logic [31:0] insnOut;
  logic [31:0] dataOut;

  int n_checks = 0;
  int n_errors = 0;

  localparam int TIMEOUT_CYC = 40;

  multdiv_controller dut (
    .clock        (clock),
    .reset        (reset),
    .insnIn       (insnIn),
    .rs           (rs),
    .rt           (rt),
    .flush        (flush),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_opA       (md_opA),
    .md_opB       (md_opB),
    .stall        (stall),
    .busy         (busy),
    .out_valid    (out_valid),
    .insnOut      (insnOut),
    .dataOut      (dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit tb_detect(input logic [31:0] i);
    return (i[31:27] == 5'd0) && ((i[6:2] == 5'b00110) || (i[6:2] == 5'b00111));
  endfunction

  function automatic logic [31:0] mk_insn(input bit is_div, input logic [4:0] rd);
    return {5'b00000, rd, 5'($urandom), 5'($urandom), 5'($urandom),
            (is_div ? 5'b00111 : 5'b00110), 2'($urandom)};
  endfunction

  function automatic logic [31:0] mk_other();
    logic [31:0] i;
    i = $urandom;
    if (tb_detect(i)) i[6:2] = 5'b00000;
    return i;
  endfunction

  // One MUL/DIV from entering execute (cycle 0) to retire or end of drain.
  // lat<0: unit never answers. flush_at>=0: flush in that cycle, then drain_insn sits in execute.
  task automatic run_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int flush_at, input logic [31:0] drain_insn,
                        input bit spurious, input string tag);
    bit          is_div;
    bit          exc;
    bit          eexc;
    logic [63:0] prod;
    logic [31:0] res;
    logic [31:0] e_insn;
    logic [31:0] e_data;
    int          ready_cyc;
    int          end_cyc;
    bit          e_cm, e_cd, e_stall, e_busy, e_valid;
    is_div = (insn[6:2] == 5'b00111);
    prod = {32'd0, a} * {32'd0, b};
    if (is_div) begin
      exc = (b == 32'd0);
      res = exc ? $urandom : a / b;
    end else begin
      exc = (prod[63:32] != 32'd0);
      res = prod[31:0];
    end
    ready_cyc = (lat < 0) ? -1 : lat + 1;
    if (flush_at >= 0) end_cyc = ready_cyc;
    else if (ready_cyc < 0) end_cyc = 2 + TIMEOUT_CYC + 1;
    else end_cyc = ready_cyc + 1;
    eexc   = (ready_cyc < 0) ? 1'b1 : exc;
    e_insn = eexc ? 32'h2F80_0000 : insn;
    if (eexc) e_data = is_div ? 32'd5 : 32'd4;
    else e_data = (insn[26:22] == 5'd0) ? 32'd0 : res;

    for (int c = 0; c <= end_cyc; c++) begin
      @(posedge clock);
      #1;
      insnIn       = (flush_at >= 0 && c > flush_at) ? drain_insn : insn;
      rs           = (c == 0) ? a : $urandom;
      rt           = (c == 0) ? b : $urandom;
      flush        = (c == flush_at);
      md_ready     = (c == ready_cyc) || (spurious && c == 1);
      md_result    = (c == ready_cyc) ? res : $urandom;
      md_exception = (c == ready_cyc) ? exc : 1'($urandom);
      #1;
      e_cm = (c == 1) && !is_div;
      e_cd = (c == 1) && is_div;
      if (flush_at >= 0) begin
        e_stall = (c > flush_at) ? tb_detect(drain_insn) : 1'b1;
        e_busy  = (c >= 1);
        e_valid = 1'b0;
      end else begin
        e_stall = (c < end_cyc);
        e_busy  = (c >= 1) && (c < end_cyc);
        e_valid = (c == end_cyc);
      end
      n_checks++;
      if (ctrl_MULT !== e_cm) begin
        n_errors++;
        $display("FAIL %s c%0d ctrl_MULT got %b exp %b", tag, c, ctrl_MULT, e_cm);
      end
      n_checks++;
      if (ctrl_DIV !== e_cd) begin
        n_errors++;
        $display("FAIL %s c%0d ctrl_DIV got %b exp %b", tag, c, ctrl_DIV, e_cd);
      end
      n_checks++;
      if (stall !== e_stall) begin
        n_errors++;
        $display("FAIL %s c%0d stall got %b exp %b", tag, c, stall, e_stall);
      end
      n_checks++;
      if (busy !== e_busy) begin
        n_errors++;
        $display("FAIL %s c%0d busy got %b exp %b", tag, c, busy, e_busy);
      end
      n_checks++;
      if (out_valid !== e_valid) begin
        n_errors++;
        $display("FAIL %s c%0d out_valid got %b exp %b", tag, c, out_valid, e_valid);
      end
      if (c >= 1) begin
        n_checks++;
        if (md_opA !== a || md_opB !== b) begin
          n_errors++;
          $display("FAIL %s c%0d operands got %h/%h exp %h/%h", tag, c, md_opA, md_opB, a, b);
        end
      end
      if (e_valid) begin
        n_checks++;
        if (insnOut !== e_insn) begin
          n_errors++;
          $display("FAIL %s insnOut got %h exp %h", tag, insnOut, e_insn);
        end
        n_checks++;
        if (dataOut !== e_data) begin
          n_errors++;
          $display("FAIL %s dataOut got %h exp %h", tag, dataOut, e_data);
        end
      end
    end
  endtask

  // Non-MUL/DIV traffic: nothing may start, stall or retire.
  task automatic check_idle(input int n, input bit stray_ready, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      insnIn       = mk_other();
      rs           = $urandom;
      rt           = $urandom;
      flush        = 1'($urandom);
      md_ready     = stray_ready && (k == 0);
      md_result    = $urandom;
      md_exception = 1'($urandom);
      #1;
      n_checks++;
      if (stall !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
          ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin
        n_errors++;
        $display("FAIL %s k%0d stall/busy/valid/mult/div got %b%b%b%b%b exp 00000",
                 tag, k, stall, busy, out_valid, ctrl_MULT, ctrl_DIV);
      end
    end
    md_ready = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    insnIn = mk_insn(1'b0, 5'd4);
    #3;
    n_checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, busy, out_valid} !== 5'b0 || insnOut !== 32'h0 ||
        dataOut !== 32'h0 || md_opA !== 32'h0 || md_opB !== 32'h0) begin
      n_errors++;
      $display("FAIL reset outputs got c%b%b s%b b%b v%b i%h d%h a%h b%h exp all zero",
               ctrl_MULT, ctrl_DIV, stall, busy, out_valid, insnOut, dataOut, md_opA, md_opB);
    end
    insnIn = 32'h0;
    @(negedge clock);
    reset = 1'b1;
    check_idle(2, 1'b1, "post_reset");
  endtask

  task automatic test_mul_basic();
    run_op(mk_insn(1'b0, 5'd5), 32'd7, 32'd6, 16, -1, 32'h0, 1'b0, "mul_basic");
  endtask

  task automatic test_div_by_zero();
    run_op(mk_insn(1'b1, 5'd8), 32'd100, 32'd0, 9, -1, 32'h0, 1'b0, "div_zero");
    run_op(mk_insn(1'b1, 5'd8), 32'd100, 32'd7, 3, -1, 32'h0, 1'b1, "div_ok");
  endtask

  task automatic test_flush();
    @(posedge clock);
    #1;
    insnIn = mk_insn(1'b0, 5'd3);
    flush  = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle stall got %b exp 0", stall);
    end
    @(posedge clock);
    #1;
    insnIn = 32'h0;
    flush  = 1'b0;
    #1;
    n_checks++;
    if (ctrl_MULT !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle start got mult%b busy%b exp 0 0", ctrl_MULT, busy);
    end
    run_op(mk_insn(1'b0, 5'd3), 32'd12, 32'd13, 12, 5, 32'h0, 1'b0, "flush_wait");
    check_idle(3, 1'b1, "after_drain");
  endtask

  task automatic test_drain_detect();
    logic [31:0] next_insn;
    next_insn = mk_insn(1'b0, 5'd9);
    run_op(mk_insn(1'b1, 5'd2), 32'd50, 32'd5, 10, 4, next_insn, 1'b0, "drain_detect");
    run_op(next_insn, 32'd11, 32'd3, 5, -1, 32'h0, 1'b0, "after_drain_op");
  endtask

  task automatic test_back_to_back();
    run_op(mk_insn(1'b1, 5'd6), 32'd90, 32'd9, 4, -1, 32'h0, 1'b0, "b2b_div1");
    run_op(mk_insn(1'b1, 5'd7), 32'd81, 32'd4, 2, -1, 32'h0, 1'b0, "b2b_div2");
  endtask

  task automatic test_timeout();
    run_op(mk_insn(1'b0, 5'd1), 32'd3, 32'd3, -1, -1, 32'h0, 1'b0, "timeout_mul");
    run_op(mk_insn(1'b1, 5'd1), 32'd3, 32'd3, -1, -1, 32'h0, 1'b0, "timeout_div");
    run_op(mk_insn(1'b0, 5'd1), 32'd5, 32'd8, TIMEOUT_CYC, -1, 32'h0, 1'b0, "late_ready");
  endtask

  task automatic test_rd_zero();
    run_op(mk_insn(1'b0, 5'd0), 32'd9, 32'd11, 6, -1, 32'h0, 1'b0, "rd_zero");
  endtask

  task automatic test_reset_mid_op();
    @(posedge clock);
    #1;
    insnIn = mk_insn(1'b0, 5'd3);
    rs     = 32'd3;
    rt     = 32'd4;
    flush  = 1'b0;
    for (int c = 1; c <= 4; c++) @(posedge clock);
    #2;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_op busy got %b exp 1", busy);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, busy, out_valid} !== 5'b0 || insnOut !== 32'h0 ||
        dataOut !== 32'h0 || md_opA !== 32'h0 || md_opB !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_op_reset got c%b%b s%b b%b v%b i%h d%h a%h b%h exp all zero",
               ctrl_MULT, ctrl_DIV, stall, busy, out_valid, insnOut, dataOut, md_opA, md_opB);
    end
    insnIn = 32'h0;
    @(negedge clock);
    reset = 1'b1;
    check_idle(4, 1'b1, "stray_ready");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          fat;
    for (int n = 0; n < 24; n++) begin
      a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5000));
      b   = ($urandom_range(0, 5) == 0) ? 32'd0
          : (($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 5000)));
      lat = int'($urandom_range(2, 20));
      fat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, lat)) : -1;
      run_op(mk_insn(1'($urandom), 5'($urandom)), a, b, lat, fat, mk_other(),
             1'($urandom), $sformatf("rand%0d", n));
      if ($urandom_range(0, 2) == 0) check_idle(int'($urandom_range(1, 2)), 1'b0, "rand_gap");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    insnIn       = 32'h0;
    rs           = 32'h0;
    rt           = 32'h0;
    flush        = 1'b0;
    md_result    = 32'h0;
    md_exception = 1'b0;
    md_ready     = 1'b0;
    test_reset();
    test_mul_basic();
    test_div_by_zero();
    test_flush();
    test_drain_detect();
    test_back_to_back();
    test_timeout();
    test_rd_zero();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
